// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer: adds two WIDTH*WORDS-bit operands one WIDTH-bit
// slice per cycle (LSB first) through an external ripple-carry adder slice.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE. out_valid is high only in DONE,
// and out_sum/out_cout stay stable until the transfer completes. Neither
// valid depends combinationally on the partner's ready.
module multiword_add_sequencer #(
    parameter int WIDTH = 4,
    parameter int WORDS = 4,
    localparam int N = WIDTH * WORDS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic             in_cin,
    output logic [WIDTH-1:0] adder_a,
    output logic [WIDTH-1:0] adder_b,
    output logic             adder_cin,
    input  logic [WIDTH-1:0] adder_sum,
    input  logic             adder_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_sum,
    output logic             out_cout,
    output logic [1:0]       state_dbg
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [IDX_W-1:0]          idx;
    logic                      carry;
    logic [WORDS-1:0][WIDTH-1:0] a_reg;
    logic [WORDS-1:0][WIDTH-1:0] b_reg;
    logic [WORDS-1:0][WIDTH-1:0] sum_reg;
    logic                      cout_reg;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and outputs; adder ports are fed from registers only and
    // are held at zero outside RUN.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        adder_a   = '0;
        adder_b   = '0;
        adder_cin = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                adder_a   = a_reg[idx];
                adder_b   = b_reg[idx];
                adder_cin = carry;
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: latch operands on accept, then capture one slice result and
    // the rippled carry per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            carry    <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            cout_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= in_a;
                        b_reg <= in_b;
                        carry <= in_cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    sum_reg[idx] <= adder_sum;
                    carry        <= adder_cout;
                    if (idx == LAST_IDX) begin
                        cout_reg <= adder_cout;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_sum   = sum_reg;
    assign out_cout  = cout_reg;
    assign state_dbg = state;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Bench for multiword_add_sequencer: models the external adder slice, keeps a
// cycle-level reference of the handshake timing and the arithmetic result, and
// runs directed cases followed by randomized traffic.
module tb_multiword_add_sequencer;

    localparam int WIDTH = 4;
    localparam int WORDS = 4;
    localparam int N     = WIDTH * WORDS;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic             in_cin;
    logic [WIDTH-1:0] adder_a;
    logic [WIDTH-1:0] adder_b;
    logic             adder_cin;
    logic [WIDTH-1:0] adder_sum;
    logic             adder_cout;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_sum;
    logic             out_cout;
    logic [1:0]       state_dbg;

    multiword_add_sequencer #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_cin     (in_cin),
        .adder_a    (adder_a),
        .adder_b    (adder_b),
        .adder_cin  (adder_cin),
        .adder_sum  (adder_sum),
        .adder_cout (adder_cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_cout   (out_cout),
        .state_dbg  (state_dbg)
    );

    // External ripple-carry slice: plain combinational addition.
    assign {adder_cout, adder_sum} = (WIDTH+1)'(adder_a) + (WIDTH+1)'(adder_b)
                                   + (WIDTH+1)'(adder_cin);

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [N:0]  exp_q[$];
    logic        cin_log[$];
    int          run_left = 0;
    bit          m_valid = 1'b0;
    logic [63:0] cur_a, cur_b;
    logic        cur_cin;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Carry entering slice k, derived from the sum of the low k slices.
    function automatic logic [63:0] slice_cin(input logic [63:0] a, input logic [63:0] b,
                                              input logic cin, input int k);
        logic [63:0] mask;
        logic [63:0] s;
        mask = (64'd1 << (k * WIDTH)) - 64'd1;
        s = (a & mask) + (b & mask) + 64'(cin);
        return (s >> (k * WIDTH)) & 64'd1;
    endfunction

    // Compare process: every cycle, check outputs against the reference and
    // advance the reference by the handshakes it sees.
    always @(negedge clk) begin
        logic [63:0] wmask;
        int          k;
        wmask = (64'd1 << WIDTH) - 64'd1;
        if (!rst_n) begin
            exp_q.delete();
            run_left = 0;
            m_valid  = 1'b0;
            chk("rst_in_ready",  64'(in_ready),  64'd1);
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_out_sum",   64'(out_sum),   64'd0);
            chk("rst_out_cout",  64'(out_cout),  64'd0);
            chk("rst_adder_cin", 64'(adder_cin), 64'd0);
        end else begin
            chk("in_ready",  64'(in_ready),  64'((run_left == 0) && !m_valid));
            chk("out_valid", 64'(out_valid), 64'(m_valid));
            if (run_left > 0) begin
                k = WORDS - run_left;
                chk("adder_a",   64'(adder_a),   (cur_a >> (k * WIDTH)) & wmask);
                chk("adder_b",   64'(adder_b),   (cur_b >> (k * WIDTH)) & wmask);
                chk("adder_cin", 64'(adder_cin), slice_cin(cur_a, cur_b, cur_cin, k));
                cin_log.push_back(adder_cin);
            end else begin
                chk("adder_idle", 64'({adder_a, adder_b, adder_cin}), 64'd0);
            end
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    chk("exp_q_empty", 64'd1, 64'd0);
                end else begin
                    chk("out_sum",  64'(out_sum),  64'(exp_q[0][N-1:0]));
                    chk("out_cout", 64'(out_cout), 64'(exp_q[0][N]));
                end
            end
            if ((run_left == 0) && !m_valid && in_valid) begin
                cur_a   = 64'(in_a);
                cur_b   = 64'(in_b);
                cur_cin = in_cin;
                exp_q.push_back((N+1)'(cur_a + cur_b + 64'(cur_cin)));
                run_left = WORDS;
            end else if (run_left > 0) begin
                run_left--;
                if (run_left == 0) m_valid = 1'b1;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin);
        bit acc;
        acc = 1'b0;
        in_a = a;
        in_b = b;
        in_cin = cin;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                acc = 1'b1;
                break;
            end
        end
        if (!acc) begin
            in_valid = 1'b0;
            chk("accept_timeout", 64'd1, 64'd0);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (out_valid) begin
                n = i;
                break;
            end
        end
        if (n == 0) chk("valid_timeout", 64'd1, 64'd0);
    endtask

    task automatic release_result();
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic directed(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic cin, input logic [N-1:0] es, input logic ec);
        int lat;
        send(a, b, cin);
        wait_valid(lat);
        chk({name, "_lat"},  64'(lat),      64'(WORDS + 1));
        chk({name, "_sum"},  64'(out_sum),  64'(es));
        chk({name, "_cout"}, 64'(out_cout), 64'(ec));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic exp_cin[4];
        int   lat;
        exp_cin = '{1'b1, 1'b1, 1'b0, 1'b0};
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_cin = 1'b0;
        out_ready = 1'b0;
        #2;
        chk("init_in_ready",  64'(in_ready),  64'd1);
        chk("init_out_valid", 64'(out_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        directed("t1", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        release_result();
        directed("t2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        release_result();

        cin_log.delete();
        directed("t3", 16'h3A9C, 16'h1234, 1'b1, 16'h4CD1, 1'b0);
        chk("t3_cin_count", 64'(cin_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < cin_log.size(); i++)
            chk("t3_cin_seq", 64'(cin_log[i]), 64'(exp_cin[i]));
        release_result();

        directed("t4", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
        release_result();

        // Result held under back-pressure while a new request is offered.
        send(16'h3A9C, 16'h1234, 1'b1);
        wait_valid(lat);
        @(posedge clk);
        #1;
        in_a = 16'h1111;
        in_b = 16'h2222;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_valid_held", 64'(out_valid), 64'd1);
            chk("t5_sum_held",   64'(out_sum),   64'h4CD1);
            chk("t5_in_ready",   64'(in_ready),  64'd0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset in the middle of RUN (slice index 2).
        send(16'hAAAA, 16'h5555, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk("t6_in_ready",  64'(in_ready),  64'd1);
        chk("t6_adder_a",   64'(adder_a),   64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        directed("t6b", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0);
        release_result();

        // Randomized traffic with random back-pressure.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom_range(0, 2) != 0);
            in_a      = N'($urandom);
            in_b      = N'($urandom);
            if ($urandom_range(0, 7) == 0) in_a = '1;
            if ($urandom_range(0, 7) == 0) in_b = '1;
            in_cin    = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("drain_idle", 64'(in_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
